// File: rtl/ps_ureg_pkg.sv
// rtl/ps_ureg_pkg.sv - PS-group ureg address map and STKY bit indices
package ps_ureg_pkg;

  localparam logic [4:0] PS_ADDR_PCSTK  = 5'b00100;
  localparam logic [4:0] PS_ADDR_PCSTKP = 5'b00101;
  localparam logic [4:0] PS_ADDR_LCNTR  = 5'b01000;
  localparam logic [4:0] PS_ADDR_MODE1  = 5'b11011;
  localparam logic [4:0] PS_ADDR_STKY   = 5'b11100;

  localparam int STKY_OVF = 0;
  localparam int STKY_UNF = 1;

endpackage

// File: rtl/ps_pcstk.sv
// rtl/ps_pcstk.sv - PC stack: pointer, entry array, push/pop and fault events
module ps_pcstk
  import ps_ureg_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int PC_W        = 16,
  parameter int PCSTK_DEPTH = 30,
  parameter int PTR_W       = $clog2(PCSTK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [PC_W-1:0]   push_dat,
  input  logic              pop,
  input  logic              ptr_wr,
  input  logic [DATA_W-1:0] ptr_wr_dat,
  output logic [PC_W-1:0]   top,
  output logic [PTR_W-1:0]  ptr,
  output logic              empty,
  output logic              full,
  output logic              ovf_evt,
  output logic              unf_evt
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(PCSTK_DEPTH);

  logic [PC_W-1:0]  entry [PCSTK_DEPTH];
  logic [PTR_W-1:0] ptr_ld;

  assign empty = (ptr == '0);
  assign full  = (ptr == PTR_MAX);
  assign top   = empty ? '0 : entry[ptr - PTR_ONE];

  always_comb begin
    ptr_ld = ptr_wr_dat[PTR_W-1:0];
    if (ptr_wr_dat > DATA_W'(PCSTK_DEPTH)) ptr_ld = PTR_MAX;
  end

  // A pointer load masks push/pop; push+pop cancels both fault conditions.
  assign ovf_evt = !ptr_wr && push && !pop && full;
  assign unf_evt = !ptr_wr && pop && !push && empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
      for (int i = 0; i < PCSTK_DEPTH; i++) entry[i] <= '0;
    end else if (ptr_wr) begin
      ptr <= ptr_ld;
    end else if (push && pop) begin
      if (empty) begin
        entry[0] <= push_dat;
        ptr      <= PTR_ONE;
      end else begin
        entry[ptr - PTR_ONE] <= push_dat;
      end
    end else if (push) begin
      if (!full) begin
        entry[ptr] <= push_dat;
        ptr        <= ptr + PTR_ONE;
      end
    end else if (pop && !empty) begin
      ptr <= ptr - PTR_ONE;
    end
  end

endmodule

// File: rtl/ps_ureg_file.sv
// rtl/ps_ureg_file.sv - PS universal-register file (PC stack, LCNTR, MODE1, STKY); PS_STK_IRQ_EN adds ps_stk_irq
module ps_ureg_file
  import ps_ureg_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int PC_W        = 16,
  parameter int PCSTK_DEPTH = 30
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [4:0]        ps_rd_add,
  input  logic [4:0]        ps_wrt_add,
  input  logic              ps_wrt_en,
  input  logic [DATA_W-1:0] ps_wrt_dat,
  input  logic              ps_pop_en,
  input  logic              ps_call_push,
  input  logic [PC_W-1:0]   ps_pc_in,
  input  logic              ps_lcntr_dec,
  output logic [DATA_W-1:0] ps_rd_dat,
  output logic [PC_W-1:0]   ps_pcstk_top,
  output logic              ps_stk_empty,
  output logic              ps_stk_full,
  output logic              ps_lcntr_zero,
  output logic [1:0]        ps_stky
`ifdef PS_STK_IRQ_EN
  ,
  output logic              ps_stk_irq
`endif
);

  localparam int PTR_W = $clog2(PCSTK_DEPTH + 1);

  logic [DATA_W-1:0] lcntr;
  logic [DATA_W-1:0] mode1;
  logic [1:0]        stky;
  logic [PTR_W-1:0]  ptr;
  logic              ovf_evt;
  logic              unf_evt;
  logic              wr_pcstk, wr_pcstkp, wr_lcntr, wr_mode1, wr_stky;
  logic              push;
  logic [PC_W-1:0]   push_dat;

  assign wr_pcstk  = ps_wrt_en && (ps_wrt_add == PS_ADDR_PCSTK);
  assign wr_pcstkp = ps_wrt_en && (ps_wrt_add == PS_ADDR_PCSTKP);
  assign wr_lcntr  = ps_wrt_en && (ps_wrt_add == PS_ADDR_LCNTR);
  assign wr_mode1  = ps_wrt_en && (ps_wrt_add == PS_ADDR_MODE1);
  assign wr_stky   = ps_wrt_en && (ps_wrt_add == PS_ADDR_STKY);

  // Sequencer push has priority; a simultaneous ureg push is dropped.
  assign push     = ps_call_push || wr_pcstk;
  assign push_dat = ps_call_push ? ps_pc_in : ps_wrt_dat[PC_W-1:0];

  ps_pcstk #(
    .DATA_W     (DATA_W),
    .PC_W       (PC_W),
    .PCSTK_DEPTH(PCSTK_DEPTH),
    .PTR_W      (PTR_W)
  ) u_pcstk (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_dat  (push_dat),
    .pop       (ps_pop_en),
    .ptr_wr    (wr_pcstkp),
    .ptr_wr_dat(ps_wrt_dat),
    .top       (ps_pcstk_top),
    .ptr       (ptr),
    .empty     (ps_stk_empty),
    .full      (ps_stk_full),
    .ovf_evt   (ovf_evt),
    .unf_evt   (unf_evt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lcntr <= '0;
      mode1 <= '0;
      stky  <= '0;
    end else begin
      if (wr_lcntr) lcntr <= ps_wrt_dat;
      else if (ps_lcntr_dec && (lcntr != '0)) lcntr <= lcntr - DATA_W'(1);
      if (wr_mode1) mode1 <= ps_wrt_dat;
      // A clear never hides a fault raised in the same cycle.
      stky[STKY_OVF] <= (stky[STKY_OVF] && !wr_stky) || ovf_evt;
      stky[STKY_UNF] <= (stky[STKY_UNF] && !wr_stky) || unf_evt;
    end
  end

`ifdef PS_STK_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ps_stk_irq <= 1'b0;
    else          ps_stk_irq <= ovf_evt || unf_evt;
  end
`endif

  assign ps_stky       = stky;
  assign ps_lcntr_zero = (lcntr == '0);

  always_comb begin
    ps_rd_dat = '0;
    case (ps_rd_add)
      PS_ADDR_PCSTK:  ps_rd_dat = DATA_W'(ps_pcstk_top);
      PS_ADDR_PCSTKP: ps_rd_dat = DATA_W'(ptr);
      PS_ADDR_LCNTR:  ps_rd_dat = lcntr;
      PS_ADDR_MODE1:  ps_rd_dat = mode1;
      PS_ADDR_STKY:   ps_rd_dat = DATA_W'(stky);
      default:        ps_rd_dat = '0;
    endcase
  end

endmodule

// File: tb/tb_ps_ureg_file.sv
// tb/tb_ps_ureg_file.sv - directed self-checking bench for ps_ureg_file
module tb_ps_ureg_file;

  localparam logic [4:0] A_PCSTK  = 5'b00100;
  localparam logic [4:0] A_PCSTKP = 5'b00101;
  localparam logic [4:0] A_LCNTR  = 5'b01000;
  localparam logic [4:0] A_MODE1  = 5'b11011;
  localparam logic [4:0] A_STKY   = 5'b11100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  ps_rd_add;
  logic [4:0]  ps_wrt_add;
  logic        ps_wrt_en;
  logic [15:0] ps_wrt_dat;
  logic        ps_pop_en;
  logic        ps_call_push;
  logic [15:0] ps_pc_in;
  logic        ps_lcntr_dec;
  logic [15:0] ps_rd_dat;
  logic [15:0] ps_pcstk_top;
  logic        ps_stk_empty;
  logic        ps_stk_full;
  logic        ps_lcntr_zero;
  logic [1:0]  ps_stky;
`ifdef PS_STK_IRQ_EN
  logic        ps_stk_irq;
`endif

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  ps_ureg_file dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ps_rd_add    (ps_rd_add),
    .ps_wrt_add   (ps_wrt_add),
    .ps_wrt_en    (ps_wrt_en),
    .ps_wrt_dat   (ps_wrt_dat),
    .ps_pop_en    (ps_pop_en),
    .ps_call_push (ps_call_push),
    .ps_pc_in     (ps_pc_in),
    .ps_lcntr_dec (ps_lcntr_dec),
    .ps_rd_dat    (ps_rd_dat),
    .ps_pcstk_top (ps_pcstk_top),
    .ps_stk_empty (ps_stk_empty),
    .ps_stk_full  (ps_stk_full),
    .ps_lcntr_zero(ps_lcntr_zero),
    .ps_stky      (ps_stky)
`ifdef PS_STK_IRQ_EN
    ,
    .ps_stk_irq   (ps_stk_irq)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
    ps_wrt_en    = 1'b0;
    ps_pop_en    = 1'b0;
    ps_call_push = 1'b0;
    ps_lcntr_dec = 1'b0;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [15:0] dat);
    ps_wrt_en  = 1'b1;
    ps_wrt_add = addr;
    ps_wrt_dat = dat;
    clk1();
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] addr, input logic [15:0] exp);
    ps_rd_add = addr;
    #1;
    chk(tag, ps_rd_dat, exp);
  endtask

  initial begin
    reset_n = 1'b0;
    ps_rd_add = '0; ps_wrt_add = '0; ps_wrt_en = 1'b0; ps_wrt_dat = '0;
    ps_pop_en = 1'b0; ps_call_push = 1'b0; ps_pc_in = '0; ps_lcntr_dec = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    rd_chk("rst_pcstkp", A_PCSTKP, 16'h0000);
    chk("rst_empty", ps_stk_empty, 1);
    chk("rst_full", ps_stk_full, 0);
    chk("rst_lzero", ps_lcntr_zero, 1);
    chk("rst_stky", ps_stky, 2'b00);
    rd_chk("rst_pcstk", A_PCSTK, 16'h0000);

    ps_call_push = 1'b1; ps_pc_in = 16'h0123; clk1();
    wr(A_PCSTK, 16'h0456);
    rd_chk("push2_ptr", A_PCSTKP, 16'd2);
    rd_chk("push2_top", A_PCSTK, 16'h0456);
    ps_pop_en = 1'b1; clk1();
    rd_chk("pop_top", A_PCSTK, 16'h0123);
    rd_chk("pop_ptr", A_PCSTKP, 16'd1);
    ps_pop_en = 1'b1; clk1();
    chk("pop_empty", ps_stk_empty, 1);

    for (int i = 0; i < 30; i++) begin
      ps_call_push = 1'b1; ps_pc_in = 16'h0100 + 16'(i); clk1();
    end
    chk("fill_full", ps_stk_full, 1);
    chk("fill_top", ps_pcstk_top, 16'h011D);
    ps_call_push = 1'b1; ps_pc_in = 16'hBEEF; clk1();
    chk("ovf_stky", ps_stky, 2'b01);
    chk("ovf_top", ps_pcstk_top, 16'h011D);
    rd_chk("ovf_ptr", A_PCSTKP, 16'd30);
`ifdef PS_STK_IRQ_EN
    chk("irq_hi", ps_stk_irq, 1);
`endif
    clk1();
`ifdef PS_STK_IRQ_EN
    chk("irq_lo", ps_stk_irq, 0);
`endif
    ps_call_push = 1'b1; ps_pc_in = 16'hBEEF; wr(A_STKY, 16'h0000);
    chk("clr_vs_fault", ps_stky, 2'b01);
    wr(A_STKY, 16'hFFFF);
    chk("stky_clr", ps_stky, 2'b00);
    rd_chk("stky_rd", A_STKY, 16'h0000);

    wr(A_PCSTKP, 16'h00FF);
    rd_chk("ptr_clamp", A_PCSTKP, 16'd30);
    wr(A_PCSTKP, 16'h0000);
    ps_pop_en = 1'b1; clk1();
    chk("unf_stky", ps_stky, 2'b10);
    rd_chk("unf_ptr", A_PCSTKP, 16'd0);
    wr(A_STKY, 16'h0000);

    ps_call_push = 1'b1; ps_pop_en = 1'b1; ps_pc_in = 16'h0AAA; clk1();
    rd_chk("pp_empty_ptr", A_PCSTKP, 16'd1);
    chk("pp_empty_stky", ps_stky, 2'b00);
    chk("pp_empty_top", ps_pcstk_top, 16'h0AAA);
    wr(A_PCSTKP, 16'd3);
    ps_call_push = 1'b1; ps_pop_en = 1'b1; ps_pc_in = 16'h0777; clk1();
    rd_chk("pp_ptr", A_PCSTKP, 16'd3);
    chk("pp_top", ps_pcstk_top, 16'h0777);
    ps_call_push = 1'b1; ps_pc_in = 16'h0999; wr(A_PCSTKP, 16'd2);
    rd_chk("ldptr_ptr", A_PCSTKP, 16'd2);
    chk("ldptr_top", ps_pcstk_top, 16'h0101);

    wr(A_LCNTR, 16'd2);
    ps_lcntr_dec = 1'b1; clk1();
    rd_chk("lc_1", A_LCNTR, 16'd1);
    chk("lc_1_zero", ps_lcntr_zero, 0);
    ps_lcntr_dec = 1'b1; clk1();
    rd_chk("lc_0", A_LCNTR, 16'd0);
    chk("lc_0_zero", ps_lcntr_zero, 1);
    ps_lcntr_dec = 1'b1; clk1();
    rd_chk("lc_hold", A_LCNTR, 16'd0);
    ps_lcntr_dec = 1'b1; wr(A_LCNTR, 16'd5);
    rd_chk("lc_wr_wins", A_LCNTR, 16'd5);

    wr(A_MODE1, 16'hA5A5);
    rd_chk("mode1", A_MODE1, 16'hA5A5);
    wr(5'b00001, 16'h1234);
    rd_chk("unmapped", 5'b00001, 16'h0000);

    wr(A_PCSTKP, 16'd5);
    ps_call_push = 1'b1; ps_pc_in = 16'h0555;
    #2 reset_n = 1'b0;
    #1;
    rd_chk("arst_ptr", A_PCSTKP, 16'd0);
    chk("arst_empty", ps_stk_empty, 1);
    chk("arst_lzero", ps_lcntr_zero, 1);
    rd_chk("arst_mode1", A_MODE1, 16'h0000);
    ps_call_push = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    rd_chk("post_rst_top", A_PCSTK, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
